mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares the 4-input, 64-bit selection datapath between four requesters.
- Picks one requester per cycle and drives the 4-bit selector code (0..3) to the shared select path.
- Captures the selected word into a single-entry output register with a valid/ready handshake.
- Supports locked multi-beat bursts.
- Sits between producer units and a single downstream consumer.

Parameters:
- WIDTH, 64, data width of each requester word and of out_data.
- SEL_W, 4, width of seletor; only codes 0..3 are ever driven.
- TIMEOUT, 16, lock watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  4  per-requester word valid.
- req_last  in  4  per-requester "final beat of burst"; 0 requests a lock.
- req_data0  in  WIDTH  requester 0 word.
- req_data1  in  WIDTH  requester 1 word.
- req_data2  in  WIDTH  requester 2 word.
- req_data3  in  WIDTH  requester 3 word.
- req_ready  out  4  one-hot accept, combinational, same cycle as the accept.
- seletor  out  SEL_W  selector code of the current winner.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIDTH  registered selected word.
- out_src  out  2  index of the requester that produced out_data.
- lock_err  out  1  sticky watchdog flag; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_src=0, seletor=0, req_ready=0, lock_err=0.
  - rr pointer ptr=0, state OPEN.
- can_accept = !out_valid || out_ready. A drain and a fill in the same cycle are allowed, giving 1 word/cycle throughput.
- OPEN state:
  - winner = first i with req_valid[i], scanning ptr, ptr+1, ... mod 4.
  - If can_accept and any req_valid: req_ready[winner]=1 and seletor=winner.
  - Next edge: out_data=selected word, out_src=winner, out_valid=1.
  - If req_last[winner]=1: ptr = winner+1 mod 4; stay OPEN.
  - If req_last[winner]=0: record owner=winner; go to LOCKED; ptr unchanged.
- LOCKED state:
  - Only the owner is eligible; other requests are ignored and their req_ready stays 0.
  - On an accepted owner beat with req_last=1: ptr = owner+1 mod 4; go to OPEN.
- No accept in a cycle:
  - seletor holds its last value.
  - out_data and out_src hold while out_valid=1 and out_ready=0.
- out_valid drops to 0 on the edge where out_ready=1 and there is no new accept.
- Latency: word accepted in cycle N appears on out_data/out_valid in cycle N+1.
- No requests: req_ready=0 and ptr unchanged.
- Reset mid-burst drops the lock and any buffered word.
- req_valid and req_data must be held by the requester until its req_ready is seen.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - In LOCKED, a counter increments each cycle the owner's req_valid=0 and clears when it is 1.
  - When the counter reaches TIMEOUT: force OPEN, set ptr = owner+1 mod 4, set lock_err=1.
  - lock_err stays set until reset.
- When not defined: a lock is held indefinitely, there is no counter, and lock_err=0.

Decomposition:
- Shared package mux_arb_pkg holds:
  - arb_state_t enum {OPEN, LOCKED}.
  - Constant N_REQ=4.
  - Constant IDX_W=2.
  - Selector code constants SEL_REQ0..SEL_REQ3 = 0..3.
- One sub-module, rr_pick: combinational, takes req_valid[3:0] and ptr[1:0], returns winner index and any flag. Instantiated once.

Test Plan:
- After reset, all four req_valid=1 and req_last=1, out_ready=1 -> grants 0,1,2,3,0 in consecutive cycles; out_src follows one cycle later; seletor=0,1,2,3,0.
- req_valid=4'b0101, ptr=1 -> requester 2 is granted first, then 0, then 2.
- Requester 1 sends 3 beats with req_last=0,0,1 while requester 3 stays valid -> req_ready[3]=0 until requester 1's third beat; requester 3 is granted the next cycle.
- out_ready=0 for 5 cycles with a word buffered -> out_data stays at 64'hDEAD_BEEF_0000_0001; no req_ready is asserted; the next accept happens on the cycle out_ready=1, same-cycle drain and fill.
- reset_n is pulled low mid-lock (asynchronously) -> out_valid=0 immediately; after release the first grant comes from index 0 in OPEN.
- ARB_TIMEOUT_EN: owner 2 locks, then idles 16 cycles -> lock_err=1 and the state returns to OPEN; requester 3 is granted next. Without the macro, the same stimulus keeps the grant locked and lock_err=0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin select arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  localparam logic [3:0] SEL_REQ0 = 4'd0;
  localparam logic [3:0] SEL_REQ1 = 4'd1;
  localparam logic [3:0] SEL_REQ2 = 4'd2;
  localparam logic [3:0] SEL_REQ3 = 4'd3;

  typedef enum logic [0:0] {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Requester index to the selector code driven to the shared select path.
  function automatic logic [3:0] idx_to_sel(input logic [IDX_W-1:0] idx);
    logic [3:0] code;
    code = SEL_REQ0;
    case (idx)
      2'd0: code = SEL_REQ0;
      2'd1: code = SEL_REQ1;
      2'd2: code = SEL_REQ2;
      2'd3: code = SEL_REQ3;
      default: code = SEL_REQ0;
    endcase
    return code;
  endfunction

  // Requester index to a one-hot request mask.
  function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting at ptr.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  logic [IDX_W-1:0] idx;

  // First valid requester at ptr, ptr+1, ... wrapping modulo N_REQ.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!any_valid && req_valid[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter with burst locking feeding a single
// registered output slot. Optional lock watchdog under ARB_TIMEOUT_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       req_valid,
  input  logic [3:0]       req_last,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
  output logic [3:0]       req_ready,
  output logic [SEL_W-1:0] seletor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  output logic             lock_err
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0] out_src_q, out_src_d;

  logic [N_REQ-1:0] elig_c;
  logic [IDX_W-1:0] winner_c;
  logic             any_c;
  logic             can_accept_c;
  logic             accept_c;
  logic [WIDTH-1:0] word_c;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_err_q, lock_err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  // While locked only the owner may win; otherwise all requesters compete.
  always_comb begin
    elig_c = req_valid;
    if (state_q == LOCKED) elig_c = req_valid & idx_onehot(owner_q);
  end

  rr_pick u_rr_pick (
    .req_valid (elig_c),
    .ptr       (ptr_q),
    .winner    (winner_c),
    .any_valid (any_c)
  );

  assign can_accept_c = !out_valid_q || out_ready;
  assign accept_c     = can_accept_c && any_c;

  // Shared 4:1 data select driven by the winner index.
  always_comb begin
    word_c = req_data0;
    case (winner_c)
      2'd0: word_c = req_data0;
      2'd1: word_c = req_data1;
      2'd2: word_c = req_data2;
      2'd3: word_c = req_data3;
      default: word_c = req_data0;
    endcase
  end

  // Next-state, handshake and output-slot update.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    req_ready   = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    lock_err_d  = lock_err_q;
`endif

    if (accept_c) begin
      req_ready   = idx_onehot(winner_c);
      sel_d       = SEL_W'(idx_to_sel(winner_c));
      out_valid_d = 1'b1;
      out_data_d  = word_c;
      out_src_d   = winner_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      OPEN: begin
        if (accept_c) begin
          if (req_last[winner_c]) begin
            ptr_d = winner_c + IDX_W'(1);
          end else begin
            owner_d = winner_c;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (accept_c && req_last[owner_q]) begin
          ptr_d   = owner_q + IDX_W'(1);
          state_d = OPEN;
        end
      end
      default: state_d = OPEN;
    endcase

`ifdef ARB_TIMEOUT_EN
    // Watchdog: count idle owner cycles; release the lock on expiry.
    if (state_q == LOCKED) begin
      if (req_valid[owner_q]) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_W'(TIMEOUT)) begin
          state_d    = OPEN;
          ptr_d      = owner_q + IDX_W'(1);
          lock_err_d = 1'b1;
          cnt_d      = '0;
        end
      end
    end else begin
      cnt_d = '0;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= OPEN;
      ptr_q       <= '0;
      owner_q     <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      lock_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      lock_err_q <= lock_err_d;
    end
  end
  assign lock_err = lock_err_q;
`else
  assign lock_err = 1'b0;
`endif

  // Selector reflects the winner during an accept, else holds the last code.
  assign seletor   = sel_d;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed testbench for mux_rr_arbiter.
module tb_mux_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [63:0] req_data0, req_data1, req_data2, req_data3;
  logic [3:0]  req_ready;
  logic [3:0]  seletor;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [1:0]  out_src;
  logic        lock_err;

  int checks   = 0;
  int failures = 0;

  mux_rr_arbiter #(.WIDTH(64), .SEL_W(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_data3 (req_data3),
    .req_ready (req_ready),
    .seletor   (seletor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .lock_err  (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One grant cycle: check combinational grant, then registered result.
  task automatic grant(input string tag, input int idx, input logic [63:0] data);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    @(negedge clk);
    chk({tag, "_rdy"}, 64'(req_ready), 64'(oh));
    chk({tag, "_sel"}, 64'(seletor), 64'(idx));
    tick();
    chk({tag, "_src"}, 64'(out_src), 64'(idx));
    chk({tag, "_data"}, out_data, data);
    chk({tag, "_ovld"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 4'b0000;
    req_last  = 4'b1111;
    out_ready = 1'b0;
    req_data0 = 64'h100;
    req_data1 = 64'h101;
    req_data2 = 64'h102;
    req_data3 = 64'h103;

    // Reset values
    #12;
    chk("rst_ovld", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_src", 64'(out_src), 64'd0);
    chk("rst_sel", 64'(seletor), 64'd0);
    chk("rst_rdy", 64'(req_ready), 64'd0);
    chk("rst_err", 64'(lock_err), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // All requesting, single beats: 0,1,2,3,0
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      grant("rr_all", k % 4, 64'h100 + 64'(k % 4));
    end

    // Sparse requests from ptr=1: 2,0,2
    req_valid = 4'b0101;
    grant("sparse_a", 2, 64'h102);
    grant("sparse_b", 0, 64'h100);
    grant("sparse_c", 2, 64'h102);

    // Three-beat lock by requester 1 with requester 3 waiting
    req_valid = 4'b0010;
    req_last  = 4'b0000;
    grant("burst_b0", 1, 64'h101);
    req_valid = 4'b1010;
    grant("burst_b1", 1, 64'h101);
    req_last  = 4'b0010;
    req_data1 = 64'h111;
    grant("burst_b2", 1, 64'h111);
    req_valid = 4'b1000;
    req_last  = 4'b1111;
    grant("burst_r3", 3, 64'h103);

    // Backpressure with a buffered word, then same-cycle drain and fill
    req_valid = 4'b0001;
    req_data0 = 64'hDEAD_BEEF_0000_0001;
    grant("bp_fill", 0, 64'hDEAD_BEEF_0000_0001);
    req_data0 = 64'hDEAD_BEEF_0000_0002;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rdy", 64'(req_ready), 64'd0);
      chk("bp_data", out_data, 64'hDEAD_BEEF_0000_0001);
      chk("bp_ovld", 64'(out_valid), 64'd1);
      chk("bp_sel", 64'(seletor), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    grant("bp_drain_fill", 0, 64'hDEAD_BEEF_0000_0002);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("idle_rdy", 64'(req_ready), 64'd0);
    chk("idle_sel_hold", 64'(seletor), 64'd0);
    tick();
    chk("idle_ovld", 64'(out_valid), 64'd0);

    // Async reset in the middle of a lock held by requester 2
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    grant("mid_lock", 2, 64'h102);
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ovld", 64'(out_valid), 64'd0);
    chk("arst_data", out_data, 64'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("arst_rdy", 64'(req_ready), 64'b0001);
    chk("arst_sel", 64'(seletor), 64'd0);
    tick();
    chk("arst_src", 64'(out_src), 64'd0);

    // Owner 2 locks, then idles while requester 3 waits
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    grant("to_lock", 2, 64'h102);
    req_valid = 4'b1000;
    req_last  = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("to_idle_rdy", 64'(req_ready), 64'd0);
      chk("to_idle_err", 64'(lock_err), 64'd0);
      tick();
    end
    chk("to_err", 64'(lock_err), TO_EN ? 64'd1 : 64'd0);
    @(negedge clk);
    chk("to_rdy", 64'(req_ready), TO_EN ? 64'b1000 : 64'd0);
    tick();
    chk("to_ovld", 64'(out_valid), TO_EN ? 64'd1 : 64'd0);
    tick();
    chk("to_err_sticky", 64'(lock_err), TO_EN ? 64'd1 : 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
